// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Drives one shared Standard_7448 BCD-to-7-segment decoder across NUM_DIGITS
// multiplexed common-cathode digits. It scans from the most significant digit
// down to digit 0. The displayed value is double-buffered, so a new value only
// takes effect at a frame boundary.
//
// Other features:
//   - power-on lamp test
//   - leading-zero blanking through the decoder's RBI pin
//   - a dead gap at the start of every digit slot, to stop ghosting
//   - per-digit blinking
//   - invalid BCD digits shown dark
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   digits_in    BCD value, nibble k = digit k (digit 0 least significant)
//   load         one-cycle strobe that captures digits_in
//   blink_mask   bit k = 1 makes digit k blink
//   lz_blank_en  enables leading-zero blanking
//   lamp_test    level, forces LT while high
//   blank        level, forces the display dark (does not suppress LT)
//   data         BCD nibble to the 7448
//   LT, RBI, BI  7448 lamp-test / ripple-blank-in / blanking-in, active-high
//   digit_sel    one-hot digit enable, active-high, all zero during the dead gap
//   frame_start  one-cycle pulse on the first cycle of each frame
//   busy         a loaded value is waiting for the next frame boundary
//
// All outputs are registered. Each clock edge registers the outputs for the
// slot position held in the counters at that edge. Level inputs therefore
// reach the outputs one cycle after they change.

module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD         = 16,
    parameter int LT_FRAMES    = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank_en,
    input  logic                    lamp_test,
    input  logic                    blank,
    output logic [3:0]              data,
    output logic                    LT,
    output logic                    RBI,
    output logic                    BI,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start,
    output logic                    busy
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = $clog2(LT_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {
        POWER_TEST,
        SCAN
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           lt_cnt;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_off;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;

    logic                    boundary;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] frame_value;
    logic [3:0]              nibble;
    logic                    upper_zero;
    logic                    visible;
    logic                    lt_now;
    logic [NUM_DIGITS-1:0]   sel_next;
    logic                    rbi_next;
    logic                    bi_next;

    assign boundary  = (slot_cnt == '0) && (idx == IW'(NUM_DIGITS - 1));
    assign frame_end = (slot_cnt == CW'(SCAN_DIV - 1)) && (idx == '0);

    // Leave the lamp test on the last cycle of the final test frame, so the
    // next frame boundary is already in SCAN.
    always_comb begin
        state_next = state;
        if ((state == POWER_TEST) && frame_end && (lt_cnt == FW'(LT_FRAMES - 1)))
            state_next = SCAN;
    end

    always_comb begin
        // A load on the boundary cycle bypasses the shadow register, so that
        // frame already shows the new value.
        frame_value = active;
        if (boundary) begin
            if (load)
                frame_value = digits_in;
            else if (busy)
                frame_value = shadow;
        end

        nibble = frame_value[4*int'(idx) +: 4];

        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(idx)) && (frame_value[4*k +: 4] != 4'd0))
                upper_zero = 1'b0;
        end

        visible  = (slot_cnt >= CW'(DEAD));
        lt_now   = (state == POWER_TEST) || lamp_test;
        sel_next = visible ? (NUM_DIGITS'(1) << idx) : '0;
        rbi_next = !lt_now && lz_blank_en && (idx != '0) && upper_zero;

        if (!visible)
            bi_next = 1'b1;
        else if (lt_now)
            bi_next = 1'b0;
        else
            bi_next = blank || (blink_mask[idx] && blink_off) || (nibble > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= POWER_TEST;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            idx         <= IW'(NUM_DIGITS - 1);
            lt_cnt      <= '0;
            blink_cnt   <= '0;
            blink_off   <= 1'b0;
            shadow      <= '0;
            active      <= '0;
            busy        <= 1'b0;
            data        <= 4'd0;
            LT          <= 1'b0;
            RBI         <= 1'b0;
            BI          <= 1'b1;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            if (slot_cnt == CW'(SCAN_DIV - 1)) begin
                slot_cnt <= '0;
                idx      <= (idx == '0) ? IW'(NUM_DIGITS - 1) : idx - 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            // Frame counters advance on the last cycle of a frame. Their new
            // values are then in place for the next frame's boundary cycle.
            if (frame_end) begin
                if (state == POWER_TEST)
                    lt_cnt <= lt_cnt + 1'b1;
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            if (load)
                shadow <= digits_in;
            if (boundary) begin
                active <= frame_value;
                busy   <= 1'b0;
            end else if (load) begin
                busy <= 1'b1;
            end

            data        <= nibble;
            LT          <= lt_now;
            RBI         <= rbi_next;
            BI          <= bi_next;
            digit_sel   <= sel_next;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

    localparam int ND  = 4;
    localparam int SD  = 8;
    localparam int DD  = 2;
    localparam int LTF = 2;
    localparam int BF  = 2;
    localparam int FL  = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blink_mask;
    logic        lz_blank_en;
    logic        lamp_test;
    logic        blank;
    logic [3:0]  data;
    logic        LT;
    logic        RBI;
    logic        BI;
    logic [3:0]  digit_sel;
    logic        frame_start;
    logic        busy;

    display_scan_controller #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .DEAD        (DD),
        .LT_FRAMES   (LTF),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .blink_mask (blink_mask),
        .lz_blank_en(lz_blank_en),
        .lamp_test  (lamp_test),
        .blank      (blank),
        .data       (data),
        .LT         (LT),
        .RBI        (RBI),
        .BI         (BI),
        .digit_sel  (digit_sel),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model. Everything is derived from p, the number of clock
    // edges since reset release. p gives slot = p % SD,
    // digit = ND-1 - (p / SD) % ND and frame = p / FL.
    int          p;
    int          m_slot, m_dig, m_frame;
    logic [15:0] m_act, m_shadow;
    logic        m_busy, m_pwr, m_vis, m_lt, m_off;
    logic [3:0]  m_nib;
    logic [3:0]  e_data, e_sel;
    logic        e_lt, e_rbi, e_bi, e_fs, e_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p = 0; m_act = 16'h0; m_shadow = 16'h0; m_busy = 1'b0;
            e_data = 4'd0; e_lt = 1'b0; e_rbi = 1'b0; e_bi = 1'b1;
            e_sel = 4'd0; e_fs = 1'b0; e_busy = 1'b0;
        end else begin
            m_slot  = p % SD;
            m_dig   = ND - 1 - (p / SD) % ND;
            m_frame = p / FL;
            if (p % FL == 0) begin
                if (load) m_act = digits_in;
                else if (m_busy) m_act = m_shadow;
                m_busy = 1'b0;
            end else if (load) begin
                m_shadow = digits_in;
                m_busy   = 1'b1;
            end
            m_nib = m_act[4*m_dig +: 4];
            m_pwr = (m_frame < LTF);
            m_vis = (m_slot >= DD);
            m_lt  = m_pwr || lamp_test;
            m_off = ((m_frame / BF) % 2) == 1;
            e_data = m_nib;
            e_lt   = m_lt;
            e_sel  = m_vis ? 4'(1 << m_dig) : 4'd0;
            e_rbi  = !m_lt && lz_blank_en && (m_dig != 0) && ((m_act >> (4*m_dig)) == 16'h0);
            e_bi   = !m_vis ? 1'b1 : (m_lt ? 1'b0 :
                     (blank || (blink_mask[m_dig] && m_off) || (m_nib > 4'd9)));
            e_fs   = (p % FL == 0);
            e_busy = m_busy;
            p++;
        end
    end

    always @(negedge clk) begin
        check("outputs{data,LT,RBI,BI,sel,fs,busy}",
              {19'd0, data, LT, RBI, BI, digit_sel, frame_start, busy},
              {19'd0, e_data, e_lt, e_rbi, e_bi, e_sel, e_fs, e_busy});
        check("onehot0", {31'd0, $onehot0(digit_sel)}, 32'd1);
    end

    logic [3:0] cap_data [ND];
    logic       cap_rbi  [ND];
    logic       cap_bi   [ND];
    logic [3:0] cap_sel  [ND];
    logic       cap_busy0;
    int         dead_cnt;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        digits_in = v;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (!frame_start && n < 4 * FL) begin
            step();
            n++;
        end
        check("frame_found", {31'd0, frame_start}, 32'd1);
    endtask

    // Finds the next frame start and records the first visible cycle of
    // each digit slot. It returns on the frame's last cycle.
    task automatic scan_frame();
        wait_frame();
        dead_cnt  = 0;
        cap_busy0 = busy;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) step();
            if (i % SD < DD && digit_sel == 4'd0) dead_cnt++;
            if (i % SD == DD) begin
                cap_data[ND-1-i/SD] = data;
                cap_rbi[ND-1-i/SD]  = RBI;
                cap_bi[ND-1-i/SD]   = BI;
                cap_sel[ND-1-i/SD]  = digit_sel;
            end
        end
    endtask

    int   lt_cnt, fs_cnt, dark_cnt;
    logic dark [8];

    initial begin
        digits_in = 16'h0; load = 1'b0; blink_mask = 4'd0;
        lz_blank_en = 1'b0; lamp_test = 1'b0; blank = 1'b0;

        repeat (3) step();
        check("rst_BI", {31'd0, BI}, 32'd1);
        check("rst_sel", {28'd0, digit_sel}, 32'd0);

        // Power-on lamp test: two frames of 32 cycles each.
        rst_n  = 1'b1;
        lt_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            lt_cnt += int'(LT);
            fs_cnt += int'(frame_start);
            if (i == 0) check("pt_fs_first", {31'd0, frame_start}, 32'd1);
        end
        check("pt_lt_cycles", lt_cnt, 32'd64);
        check("pt_fs_count", fs_cnt, 32'd2);
        step();
        check("pt_lt_end", {31'd0, LT}, 32'd0);
        check("pt_fs_64", {31'd0, frame_start}, 32'd1);

        // Scan order and timing.
        pulse_load(16'h1234);
        scan_frame();
        check("scan_dead", dead_cnt, 32'd8);
        check("scan_d3", {28'd0, cap_data[3]}, 32'd1);
        check("scan_d2", {28'd0, cap_data[2]}, 32'd2);
        check("scan_d1", {28'd0, cap_data[1]}, 32'd3);
        check("scan_d0", {28'd0, cap_data[0]}, 32'd4);
        check("scan_sel3", {28'd0, cap_sel[3]}, 32'h8);
        check("scan_sel0", {28'd0, cap_sel[0]}, 32'h1);

        // Leading-zero blanking.
        lz_blank_en = 1'b1;
        pulse_load(16'h0400);
        scan_frame();
        check("lz0400_rbi3", {31'd0, cap_rbi[3]}, 32'd1);
        check("lz0400_rbi2", {31'd0, cap_rbi[2]}, 32'd0);
        check("lz0400_rbi1", {31'd0, cap_rbi[1]}, 32'd0);
        pulse_load(16'h0000);
        scan_frame();
        check("lz0000_rbi3", {31'd0, cap_rbi[3]}, 32'd1);
        check("lz0000_rbi1", {31'd0, cap_rbi[1]}, 32'd1);
        check("lz0000_rbi0", {31'd0, cap_rbi[0]}, 32'd0);
        check("lz0000_bi0", {31'd0, cap_bi[0]}, 32'd0);
        lz_blank_en = 1'b0;

        // Double buffer: the last load in a frame wins at the next frame boundary.
        wait_frame();
        repeat (4) step();
        pulse_load(16'h1111);
        step();
        pulse_load(16'h2222);
        check("db_busy", {31'd0, busy}, 32'd1);
        repeat (3) step();
        check("db_unchanged", {28'd0, data}, 32'd0);
        scan_frame();
        check("db_busy_clear", {31'd0, cap_busy0}, 32'd0);
        check("db_new3", {28'd0, cap_data[3]}, 32'd2);
        check("db_new0", {28'd0, cap_data[0]}, 32'd2);

        // A load on the boundary cycle shows up in that same frame.
        digits_in = 16'h5678;
        load      = 1'b1;
        step();
        load      = 1'b0;
        check("bnd_fs", {31'd0, frame_start}, 32'd1);
        check("bnd_data", {28'd0, data}, 32'd5);
        check("bnd_busy", {31'd0, busy}, 32'd0);

        // Lamp test overrides blank.
        step();
        lamp_test = 1'b1;
        blank     = 1'b1;
        step();
        check("ovr_LT", {31'd0, LT}, 32'd1);
        check("ovr_BI", {31'd0, BI}, 32'd0);
        lamp_test = 1'b0;
        step();
        check("blank_BI", {31'd0, BI}, 32'd1);
        blank = 1'b0;

        // A nibble that is not valid BCD is shown dark.
        pulse_load(16'h000A);
        scan_frame();
        check("bad_bcd_bi0", {31'd0, cap_bi[0]}, 32'd1);
        check("bad_bcd_bi1", {31'd0, cap_bi[1]}, 32'd0);

        // Blink: digit 0 is dark for two frames, then lit for two frames.
        pulse_load(16'h1234);
        blink_mask = 4'b0001;
        dark_cnt   = 0;
        for (int f = 0; f < 8; f++) begin
            scan_frame();
            dark[f] = cap_bi[0];
            dark_cnt += int'(cap_bi[0]);
        end
        check("blink_dark_frames", dark_cnt, 32'd4);
        for (int f = 0; f < 6; f++)
            check("blink_period", {31'd0, dark[f] ^ dark[f+2]}, 32'd1);
        blink_mask = 4'd0;

        // Asynchronous reset in the middle of a slot.
        wait_frame();
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_BI", {31'd0, BI}, 32'd1);
        check("arst_sel", {28'd0, digit_sel}, 32'd0);
        check("arst_data", {28'd0, data}, 32'd0);
        check("arst_LT", {31'd0, LT}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("arst_pt_LT", {31'd0, LT}, 32'd1);
        check("arst_pt_fs", {31'd0, frame_start}, 32'd1);

        // Random traffic, checked against the model on every cycle.
        for (int i = 0; i < 3000; i++) begin
            load      = ($urandom % 12) == 0;
            digits_in = 16'($urandom);
            if ($urandom % 40 == 0) blink_mask  = 4'($urandom);
            if ($urandom % 40 == 0) lz_blank_en = 1'($urandom);
            if ($urandom % 60 == 0) blank       = 1'($urandom);
            if ($urandom % 90 == 0) lamp_test   = ($urandom % 3) == 0;
            step();
        end
        load = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
